// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state and
// instruction-class enums, opcode/func codes and datapath select encodings.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_RALU    = 4'd0,
        C_IALU    = 4'd1,
        C_LOAD    = 4'd2,
        C_STORE   = 4'd3,
        C_BRANCH  = 4'd4,
        C_JUMP    = 4'd5,
        C_JREG    = 4'd6,
        C_LINK    = 4'd7,
        C_ILLEGAL = 4'd8
    } iclass_t;

    // R-type func codes (also used directly as ALU operation codes)
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2a;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    // Select encodings
    localparam logic [1:0] SEL_PC_PC4  = 2'd0;
    localparam logic [1:0] SEL_PC_JMP  = 2'd1;
    localparam logic [1:0] SEL_PC_BR   = 2'd2;
    localparam logic [1:0] SEL_PC_RS   = 2'd3;
    localparam logic [1:0] SEL_DEST_RT = 2'd0;
    localparam logic [1:0] SEL_DEST_RD = 2'd1;
    localparam logic [1:0] SEL_DEST_RA = 2'd2;
    localparam logic [1:0] SEL_DATA_ALU = 2'd0;
    localparam logic [1:0] SEL_DATA_MEM = 2'd1;
    localparam logic [1:0] SEL_DATA_PC  = 2'd2;

    // Decoded instruction: class plus the per-instruction ALU details
    typedef struct packed {
        iclass_t    cls;
        logic [5:0] alu_op;
        logic       shamt;   // operand A comes from shamt (SLL/SRL)
        logic       bne;     // branch on not-equal
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier for mc_control.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_func,
    output dec_t       o_dec
);

    // Map opcode/func to instruction class and ALU controls
    always_comb begin
        o_dec.cls    = C_ILLEGAL;
        o_dec.alu_op = FN_ADD;
        o_dec.shamt  = 1'b0;
        o_dec.bne    = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_func)
                    FN_ADD, FN_SUB, FN_SLT: begin
                        o_dec.cls    = C_RALU;
                        o_dec.alu_op = i_func;
                    end
                    FN_SLL, FN_SRL: begin
                        o_dec.cls    = C_RALU;
                        o_dec.alu_op = i_func;
                        o_dec.shamt  = 1'b1;
                    end
                    FN_JR:   o_dec.cls = C_JREG;
                    default: o_dec.cls = C_ILLEGAL;
                endcase
            end
            OP_ADDI: o_dec.cls = C_IALU;
            OP_SLTI: begin
                o_dec.cls    = C_IALU;
                o_dec.alu_op = FN_SLT;
            end
            OP_LW:   o_dec.cls = C_LOAD;
            OP_SW:   o_dec.cls = C_STORE;
            OP_BEQ: begin
                o_dec.cls    = C_BRANCH;
                o_dec.alu_op = FN_SUB;
            end
            OP_BNE: begin
                o_dec.cls    = C_BRANCH;
                o_dec.alu_op = FN_SUB;
                o_dec.bne    = 1'b1;
            end
            OP_J:    o_dec.cls = C_JUMP;
            OP_JAL:  o_dec.cls = C_LINK;
            default: o_dec.cls = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB).
// Optional build macro MC_MEM_WAIT_EN adds the mem_rdy handshake that
// stretches FETCH and MEM until memory is ready.
module mc_control
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zf,
`ifdef MC_MEM_WAIT_EN
    input  logic       mem_rdy,
`endif
    output logic       ir_wr,
    output logic       pc_wr,
    output logic [1:0] sel_pc,
    output logic [1:0] sel_dest,
    output logic [1:0] sel_data,
    output logic       sel_opA,
    output logic       sel_opB,
    output logic [5:0] alu_op,
    output logic       wr_en,
    output logic       data_wr,
    output logic       instr_done,
    output logic       illegal
);

    state_t r_state;
    state_t w_next;
    dec_t   w_dec;
    logic   w_rdy;

`ifdef MC_MEM_WAIT_EN
    assign w_rdy = mem_rdy;
`else
    assign w_rdy = 1'b1;
`endif

    mc_decode u_decode (
        .i_opcode (opcode),
        .i_func   (func),
        .o_dec    (w_dec)
    );

    // State register; asynchronous reset returns to FETCH
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Next-state selection
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = w_rdy ? S_DECODE : S_FETCH;
            S_DECODE: w_next = (w_dec.cls == C_ILLEGAL) ? S_FETCH : S_EXEC;
            S_EXEC: begin
                case (w_dec.cls)
                    C_LOAD, C_STORE:                     w_next = S_MEM;
                    C_RALU, C_IALU, C_LINK:              w_next = S_WB;
                    default:                             w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (!w_rdy)                     w_next = S_MEM;
                else if (w_dec.cls == C_STORE)  w_next = S_FETCH;
                else                            w_next = S_WB;
            end
            default:  w_next = S_FETCH;
        endcase
    end

    // Datapath controls; everything is held inactive while nrst is low
    always_comb begin
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        sel_pc     = SEL_PC_PC4;
        sel_dest   = SEL_DEST_RT;
        sel_data   = SEL_DATA_ALU;
        sel_opA    = 1'b0;
        sel_opB    = 1'b0;
        alu_op     = FN_ADD;
        wr_en      = 1'b0;
        data_wr    = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (nrst) begin
            case (r_state)
                S_FETCH: begin
                    ir_wr = w_rdy;
                    pc_wr = w_rdy;
                end
                S_DECODE: begin
                    if (w_dec.cls == C_ILLEGAL) begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_EXEC: begin
                    case (w_dec.cls)
                        C_RALU: begin
                            alu_op  = w_dec.alu_op;
                            sel_opA = w_dec.shamt;
                        end
                        C_IALU: begin
                            alu_op  = w_dec.alu_op;
                            sel_opB = 1'b1;
                        end
                        C_LOAD, C_STORE: sel_opB = 1'b1;
                        C_BRANCH: begin
                            alu_op     = w_dec.alu_op;
                            pc_wr      = w_dec.bne ? ~zf : zf;
                            sel_pc     = SEL_PC_BR;
                            instr_done = 1'b1;
                        end
                        C_JUMP: begin
                            pc_wr      = 1'b1;
                            sel_pc     = SEL_PC_JMP;
                            instr_done = 1'b1;
                        end
                        C_JREG: begin
                            pc_wr      = 1'b1;
                            sel_pc     = SEL_PC_RS;
                            instr_done = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    sel_opB = 1'b1;
                    if (w_dec.cls == C_STORE) begin
                        data_wr    = 1'b1;
                        instr_done = w_rdy;
                    end
                end
                S_WB: begin
                    wr_en      = 1'b1;
                    instr_done = 1'b1;
                    case (w_dec.cls)
                        C_RALU: sel_dest = SEL_DEST_RD;
                        C_LOAD: sel_data = SEL_DATA_MEM;
                        C_LINK: begin
                            // $ra takes PC+4 while the PC loads the jump target
                            sel_dest = SEL_DEST_RA;
                            sel_data = SEL_DATA_PC;
                            pc_wr    = 1'b1;
                            sel_pc   = SEL_PC_JMP;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
